// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: md_op codes and FSM states.
package ex_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Handshake bundle between the ID/EX pipe register (master) and the mul/div unit (slave).
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             exe_stall;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [1:0]       hilo_we;

  modport master (
    output start, md_op, src_a, src_b, flush,
    input  exe_stall, md_done, md_hi, md_lo, hilo_we
  );

  modport slave (
    input  start, md_op, src_a, src_b, flush,
    output exe_stall, md_done, md_hi, md_lo, hilo_we
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// One iteration of the unsigned datapath: right-shifting shift-add multiply or
// left-shifting restoring divide over the {acc, lo} register pair. Purely combinational.
module ex_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // diff[WIDTH] is the borrow: the partial remainder is always below the divisor,
  // so a successful subtract never sets the top bit.
  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, (lo_i[0] ? opnd_i : {WIDTH{1'b0}})};
    shifted = {acc_i, lo_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};
    acc_o   = sum[WIDTH:1];
    lo_o    = {sum[0], lo_i[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        lo_o  = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        lo_o  = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit stalling ID/EX until HI/LO are ready.
// Optional FAST_MUL_EN: multiplies finish in a single step (IDLE -> DONE).
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       reset,
  ex_muldiv_if.slave md
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] md_hi_q, md_hi_d, md_lo_q, md_lo_d;
  logic             is_div_q, is_div_d, res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;

  logic [WIDTH-1:0]   acc_step, lo_step, abs_a, abs_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic               a_neg, b_neg, op_div, issue, done;

`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{a_neg}}, md.src_a} * {{WIDTH{b_neg}}, md.src_b};
`endif

  ex_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step),
    .lo_o   (lo_step)
  );

  always_comb begin
    a_neg    = md_is_signed(md.md_op) & md.src_a[WIDTH-1];
    b_neg    = md_is_signed(md.md_op) & md.src_b[WIDTH-1];
    op_div   = md.md_op[1];
    abs_a    = a_neg ? -md.src_a : md.src_a;
    abs_b    = b_neg ? -md.src_b : md.src_b;
    issue    = (state_q == MD_IDLE) & md.start & ~md.flush;
    done     = (state_q == MD_DONE) & ~md.flush;
    prod_fix = res_neg_q ? -{acc_step, lo_step} : {acc_step, lo_step};
    quo_fix  = res_neg_q ? -lo_step : lo_step;
    rem_fix  = rem_neg_q ? -acc_step : acc_step;
  end

  // A zero divisor must leave the all-ones quotient unnegated, hence the |src_b term.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    md_hi_d   = md_hi_q;
    md_lo_d   = md_lo_q;
    case (state_q)
      MD_IDLE: begin
        if (issue) begin
          state_d   = MD_BUSY;
          cnt_d     = '0;
          acc_d     = '0;
          is_div_d  = op_div;
          lo_d      = op_div ? abs_a : abs_b;
          opnd_d    = op_div ? abs_b : abs_a;
          res_neg_d = (a_neg ^ b_neg) & (~op_div | (|md.src_b));
          rem_neg_d = op_div & a_neg;
`ifdef FAST_MUL_EN
          if (!op_div) begin
            state_d = MD_DONE;
            md_hi_d = fast_prod[2*WIDTH-1:WIDTH];
            md_lo_d = fast_prod[WIDTH-1:0];
          end
`endif
        end
      end
      MD_BUSY: begin
        if (md.flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = acc_step;
          lo_d  = lo_step;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = MD_DONE;
            md_hi_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            md_lo_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      md_hi_q   <= '0;
      md_lo_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      md_hi_q   <= md_hi_d;
      md_lo_q   <= md_lo_d;
    end
  end

  assign md.exe_stall = issue | (state_q == MD_BUSY);
  assign md.md_done   = done;
  assign md.hilo_we   = {done, done};
  assign md.md_hi     = md_hi_q;
  assign md.md_lo     = md_lo_q;

endmodule
